// File: rtl/bus_cycle_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_cycle_timer
// Purpose  : Timing sequencer for parallel bus cycles (address/dir, read,
//            write). A single counter runs per cycle and every bus strobe is
//            decoded from that count against per-mode phase windows.
// Ports    : clk, rst (async, active-high)
//            En_dir/En_rd/En_wr : cycle requests from the bus-control FSM
//            count              : current cycle count
//            busy               : cycle in progress or holding at terminal
//            ale, cs_n, rd_n, wr_n, data_oe : bus pin controls
//            rd_sample          : one-cycle read-data capture pulse
//            done/abort/err     : one-cycle status pulses
// Revision : 1.0 - initial release
// ============================================================================
module bus_cycle_timer #(
  parameter int CNT_W   = 5,
  parameter int T_DIR   = 23,
  parameter int T_RD    = 23,
  parameter int T_WR    = 23,
  parameter int ALE_ON  = 1,
  parameter int ALE_OFF = 3,
  parameter int CS_ON   = 2,
  parameter int CS_OFF  = 14,
  parameter int STB_ON  = 4,
  parameter int STB_OFF = 12,
  parameter int SAMPLE  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En_dir,
  input  logic             En_rd,
  input  logic             En_wr,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             ale,
  output logic             cs_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic             data_oe,
  output logic             rd_sample,
  output logic             done,
  output logic             abort,
  output logic             err
);

  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_T_DIR   = CNT_W'(T_DIR);
  localparam logic [CNT_W-1:0] C_T_RD    = CNT_W'(T_RD);
  localparam logic [CNT_W-1:0] C_T_WR    = CNT_W'(T_WR);
  localparam logic [CNT_W-1:0] C_ALE_ON  = CNT_W'(ALE_ON);
  localparam logic [CNT_W-1:0] C_ALE_OFF = CNT_W'(ALE_OFF);
  localparam logic [CNT_W-1:0] C_CS_ON   = CNT_W'(CS_ON);
  localparam logic [CNT_W-1:0] C_CS_OFF  = CNT_W'(CS_OFF);
  localparam logic [CNT_W-1:0] C_STB_ON  = CNT_W'(STB_ON);
  localparam logic [CNT_W-1:0] C_STB_OFF = CNT_W'(STB_OFF);
  localparam logic [CNT_W-1:0] C_SAMPLE  = CNT_W'(SAMPLE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;
  typedef enum logic [1:0] {M_NONE = 2'd0, M_DIR = 2'd1, M_RD = 2'd2, M_WR = 2'd3} mode_t;

  state_t           state, state_nx;
  mode_t            mode, mode_nx;
  logic [CNT_W-1:0] count_nx;
  logic             done_nx, abort_nx, err_nx;
  logic             en_lat;
  logic             act;
  logic             wr_like;

  function automatic logic [CNT_W-1:0] term_of(input mode_t m);
    case (m)
      M_DIR:   term_of = C_T_DIR;
      M_RD:    term_of = C_T_RD;
      default: term_of = C_T_WR;
    endcase
  endfunction

  // Only the enable that started the cycle matters once it is running.
  always_comb begin
    case (mode)
      M_DIR:   en_lat = En_dir;
      M_RD:    en_lat = En_rd;
      M_WR:    en_lat = En_wr;
      default: en_lat = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    count_nx = count;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (En_dir || En_rd || En_wr) begin
          mode_nx  = En_dir ? M_DIR : (En_rd ? M_RD : M_WR);
          err_nx   = (En_dir & En_rd) | (En_dir & En_wr) | (En_rd & En_wr);
          count_nx = C_ONE;
          if (term_of(mode_nx) == C_ONE) begin
            state_nx = S_HOLD;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!en_lat) begin
          state_nx = S_IDLE;
          mode_nx  = M_NONE;
          count_nx = '0;
          abort_nx = 1'b1;
        end else begin
          // count < terminal in RUN, so the increment cannot wrap.
          count_nx = count + C_ONE;
          if (count_nx == term_of(mode)) begin
            state_nx = S_HOLD;
            done_nx  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!en_lat) begin
          state_nx = S_IDLE;
          mode_nx  = M_NONE;
          count_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        mode_nx  = M_NONE;
        count_nx = '0;
      end
    endcase
  end

  // Strobes are live while running and on the terminal cycle itself.
  assign act     = (state_nx == S_RUN) || done_nx;
  assign wr_like = (mode_nx == M_DIR) || (mode_nx == M_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mode      <= M_NONE;
      count     <= '0;
      busy      <= 1'b0;
      ale       <= 1'b0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      data_oe   <= 1'b0;
      rd_sample <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      mode      <= mode_nx;
      count     <= count_nx;
      busy      <= (state_nx != S_IDLE);
      ale       <= act && (mode_nx == M_DIR) &&
                   (count_nx >= C_ALE_ON) && (count_nx <= C_ALE_OFF);
      cs_n      <= !(act && (count_nx >= C_CS_ON) && (count_nx <= C_CS_OFF));
      rd_n      <= !(act && (mode_nx == M_RD) &&
                     (count_nx >= C_STB_ON) && (count_nx <= C_STB_OFF));
      wr_n      <= !(act && wr_like &&
                     (count_nx >= C_STB_ON) && (count_nx <= C_STB_OFF));
      data_oe   <= act && wr_like &&
                   (count_nx >= C_CS_ON) && (count_nx <= C_CS_OFF);
      rd_sample <= act && (mode_nx == M_RD) && (count_nx == C_SAMPLE);
      done      <= done_nx;
      abort     <= abort_nx;
      err       <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_timer
// Purpose  : Self-checking bench for bus_cycle_timer: directed scenarios with
//            literal expectations plus randomized enables against a
//            behavioural cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_timer;
  localparam int CNT_W = 5, T_DIR = 23, T_RD = 23, T_WR = 23;
  localparam int ALE_ON = 1, ALE_OFF = 3, CS_ON = 2, CS_OFF = 14;
  localparam int STB_ON = 4, STB_OFF = 12, SAMPLE = 11;

  logic clk, rst, en_dir, en_rd, en_wr;
  logic [CNT_W-1:0] count;
  logic busy, ale, cs_n, rd_n, wr_n, data_oe, rd_sample, done, abort, err;

  bus_cycle_timer #(
    .CNT_W(CNT_W), .T_DIR(T_DIR), .T_RD(T_RD), .T_WR(T_WR),
    .ALE_ON(ALE_ON), .ALE_OFF(ALE_OFF), .CS_ON(CS_ON), .CS_OFF(CS_OFF),
    .STB_ON(STB_ON), .STB_OFF(STB_OFF), .SAMPLE(SAMPLE)
  ) dut (
    .clk(clk), .rst(rst), .En_dir(en_dir), .En_rd(en_rd), .En_wr(en_wr),
    .count(count), .busy(busy), .ale(ale), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .data_oe(data_oe), .rd_sample(rd_sample), .done(done),
    .abort(abort), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Behavioural model: busy flag, mode (0 none,1 dir,2 rd,3 wr), count, pulses.
  int m_busy, m_mode, m_cnt, m_done, m_abort, m_err;

  // Per-scenario observations of the DUT.
  int n_cs, n_wr, n_rd, n_oe, n_ale, n_done, n_abort, n_err, n_smp;
  int cs_min, cs_max, stb_min, stb_max, ale_min, ale_max, smp_cnt, done_cnt;

  function automatic int term_of(input int md);
    return (md == 1) ? T_DIR : ((md == 2) ? T_RD : T_WR);
  endfunction

  function automatic bit in_win(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_mode = 0; m_cnt = 0; m_done = 0; m_abort = 0; m_err = 0;
  endtask

  task automatic model_step();
    int t;
    bit lat;
    if (rst) begin
      model_reset();
      return;
    end
    m_done = 0; m_abort = 0; m_err = 0;
    if (m_busy == 0) begin
      if (en_dir || en_rd || en_wr) begin
        m_busy = 1;
        m_mode = en_dir ? 1 : (en_rd ? 2 : 3);
        m_cnt  = 1;
        m_err  = ((int'(en_dir) + int'(en_rd) + int'(en_wr)) > 1) ? 1 : 0;
        m_done = (m_cnt == term_of(m_mode)) ? 1 : 0;
      end
    end else begin
      t   = term_of(m_mode);
      lat = (m_mode == 1) ? en_dir : ((m_mode == 2) ? en_rd : en_wr);
      if (!lat) begin
        m_abort = (m_cnt < t) ? 1 : 0;
        m_busy  = 0;
        m_cnt   = 0;
        m_mode  = 0;
      end else if (m_cnt < t) begin
        m_cnt++;
        m_done = (m_cnt == t) ? 1 : 0;
      end
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic compare_all();
    bit act, wl;
    logic [14:0] e, a;
    act = (m_busy != 0) && ((m_cnt < term_of(m_mode)) || (m_done != 0));
    wl  = (m_mode == 1) || (m_mode == 3);
    e = {CNT_W'(m_cnt), m_busy != 0,
         act && m_mode == 1 && in_win(m_cnt, ALE_ON, ALE_OFF),
         !(act && in_win(m_cnt, CS_ON, CS_OFF)),
         !(act && m_mode == 2 && in_win(m_cnt, STB_ON, STB_OFF)),
         !(act && wl && in_win(m_cnt, STB_ON, STB_OFF)),
         act && wl && in_win(m_cnt, CS_ON, CS_OFF),
         act && m_mode == 2 && m_cnt == SAMPLE,
         m_done != 0, m_abort != 0, m_err != 0};
    a = {count, busy, ale, cs_n, rd_n, wr_n, data_oe, rd_sample, done, abort, err};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL model_cmp t=%0t actual cnt=%0d flags=%b expected cnt=%0d flags=%b",
               $time, a[14:10], a[9:0], e[14:10], e[9:0]);
    end
  endtask

  task automatic clear_stats();
    n_cs = 0; n_wr = 0; n_rd = 0; n_oe = 0; n_ale = 0; n_done = 0;
    n_abort = 0; n_err = 0; n_smp = 0;
    cs_min = 99; cs_max = -1; stb_min = 99; stb_max = -1;
    ale_min = 99; ale_max = -1; smp_cnt = -1; done_cnt = -1;
  endtask

  task automatic tick();
    int c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    c = int'(count);
    if (!cs_n) begin n_cs++; if (c < cs_min) cs_min = c; if (c > cs_max) cs_max = c; end
    if (!wr_n || !rd_n) begin
      if (c < stb_min) stb_min = c;
      if (c > stb_max) stb_max = c;
    end
    if (!wr_n) n_wr++;
    if (!rd_n) n_rd++;
    if (data_oe) n_oe++;
    if (ale) begin n_ale++; if (c < ale_min) ale_min = c; if (c > ale_max) ale_max = c; end
    if (done) begin n_done++; done_cnt = c; end
    if (abort) n_abort++;
    if (err) n_err++;
    if (rd_sample) begin n_smp++; smp_cnt = c; end
  endtask

  initial begin
    int k;
    rst = 1'b1; en_dir = 1'b0; en_rd = 1'b0; en_wr = 1'b0;
    model_reset();
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_rd_wr_n", int'({rd_n, wr_n}), 3);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Write cycle held past terminal.
    clear_stats();
    en_wr = 1'b1;
    repeat (30) tick();
    check("wr_final_count", int'(count), 23);
    check("wr_busy_hold", int'(busy), 1);
    check("wr_cs_low_n", n_cs, 13);
    check("wr_cs_min", cs_min, 2);
    check("wr_cs_max", cs_max, 14);
    check("wr_wr_low_n", n_wr, 9);
    check("wr_stb_min", stb_min, 4);
    check("wr_stb_max", stb_max, 12);
    check("wr_oe_n", n_oe, 13);
    check("wr_done_n", n_done, 1);
    check("wr_done_cnt", done_cnt, 23);
    check("wr_ale_n", n_ale, 0);
    en_wr = 1'b0;
    tick();
    check("wr_hold_drop_count", int'(count), 0);
    check("wr_hold_drop_abort", int'(abort), 0);

    // Read cycle held past terminal.
    clear_stats();
    en_rd = 1'b1;
    repeat (30) tick();
    check("rd_rd_low_n", n_rd, 9);
    check("rd_stb_min", stb_min, 4);
    check("rd_stb_max", stb_max, 12);
    check("rd_sample_n", n_smp, 1);
    check("rd_sample_cnt", smp_cnt, 11);
    check("rd_wr_low_n", n_wr, 0);
    check("rd_oe_n", n_oe, 0);
    en_rd = 1'b0;
    tick();

    // Dir cycle aborted at count 8.
    clear_stats();
    en_dir = 1'b1;
    k = 0;
    while (count != 8 && k < 40) begin tick(); k++; end
    check("dir_reach8", int'(count), 8);
    en_dir = 1'b0;
    tick();
    check("dir_abort_count", int'(count), 0);
    check("dir_abort_pulse", int'(abort), 1);
    check("dir_abort_strobes", int'({cs_n, wr_n, ale, data_oe}), 4'b1100);
    check("dir_done_n", n_done, 0);
    check("dir_ale_n", n_ale, 3);
    check("dir_ale_min", ale_min, 1);
    check("dir_ale_max", ale_max, 3);
    tick();
    check("dir_abort_one_cycle", int'(abort), 0);

    // Two enables together: read wins, err pulses once.
    clear_stats();
    en_rd = 1'b1; en_wr = 1'b1;
    tick();
    check("multi_err", int'(err), 1);
    tick();
    check("multi_err_once", int'(err), 0);
    repeat (3) tick();
    en_wr = 1'b0;
    repeat (25) tick();
    check("multi_err_n", n_err, 1);
    check("multi_rd_low_n", n_rd, 9);
    check("multi_wr_low_n", n_wr, 0);
    check("multi_sample_n", n_smp, 1);
    check("multi_done_n", n_done, 1);
    en_rd = 1'b0;
    tick();

    // Restart after hold, then asynchronous reset mid-run.
    clear_stats();
    en_wr = 1'b1;
    repeat (30) tick();
    en_wr = 1'b0;
    tick();
    check("restart_gap_count", int'(count), 0);
    en_wr = 1'b1;
    tick();
    check("restart_count", int'(count), 1);
    check("restart_busy", int'(busy), 1);
    check("restart_abort_n", n_abort, 0);
    k = 0;
    while (count != 7 && k < 40) begin tick(); k++; end
    check("rst_mid_reach7", int'(count), 7);
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_strobes_n", int'({cs_n, rd_n, wr_n}), 7);
    check("rst_mid_done_abort", int'({done, abort}), 0);
    en_wr = 1'b0;
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    tick();

    // Randomized enables with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) en_dir = ~en_dir;
      if ($urandom_range(0, 9) == 0) en_rd  = ~en_rd;
      if ($urandom_range(0, 9) == 0) en_wr  = ~en_wr;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
